// File: rtl/tank_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tank_pkg
// Purpose  : Shared types and default key maps for the per-player tank
//            controller (facing direction, weapon states, keycodes).
// Revision : 1.0 - initial release
// ============================================================================
package tank_pkg;

  // Facing direction, encoded as reported on the Direction output
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  // Weapon state machine states
  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_RELOAD   = 2'd2
  } weapon_state_t;

  // Player A key map (J/L/K/I, Enter fires, P reloads)
  localparam logic [7:0] KEYA_LEFT   = 8'h0d;
  localparam logic [7:0] KEYA_RIGHT  = 8'h0f;
  localparam logic [7:0] KEYA_DOWN   = 8'h0e;
  localparam logic [7:0] KEYA_UP     = 8'h0c;
  localparam logic [7:0] KEYA_FIRE   = 8'h28;
  localparam logic [7:0] KEYA_RELOAD = 8'h13;

  // Player B key map (A/D/S/W, Space fires, R reloads)
  localparam logic [7:0] KEYB_LEFT   = 8'h04;
  localparam logic [7:0] KEYB_RIGHT  = 8'h07;
  localparam logic [7:0] KEYB_DOWN   = 8'h16;
  localparam logic [7:0] KEYB_UP     = 8'h1a;
  localparam logic [7:0] KEYB_FIRE   = 8'h2c;
  localparam logic [7:0] KEYB_RELOAD = 8'h15;

endpackage
`default_nettype wire

// File: rtl/tank_weapon_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tank_weapon_fsm
// Purpose  : Weapon control: fire-key edge detect, ammo magazine, post-shot
//            cooldown and timed reload. Produces a one-frame shoot pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tank_weapon_fsm
  import tank_pkg::*;
#(
  parameter int AMMO_MAX = 3,
  parameter int COOLDOWN = 8,
  parameter int RELOAD   = 60,
  parameter int AMMO_W   = $clog2(AMMO_MAX + 1)
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic              fire_req_i,    // fire key held this frame (level)
  input  logic              reload_req_i,  // reload key held this frame
  output logic              shoot_o,
  output logic [AMMO_W-1:0] ammo_o,
  output logic              reloading_o
);

  localparam int CNT_MAX = (COOLDOWN > RELOAD) ? COOLDOWN : RELOAD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  c_CD_LOAD   = CNT_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0]  c_RL_LOAD   = CNT_W'(RELOAD - 1);
  localparam logic [AMMO_W-1:0] c_AMMO_FULL = AMMO_W'(AMMO_MAX);

  weapon_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AMMO_W-1:0] ammo_q, ammo_d;
  logic              shoot_q, shoot_d;
  logic              fire_prev_q;
  logic              w_fire_edge;

  // State, counter, magazine and fire-key history registers
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_READY;
      cnt_q       <= '0;
      ammo_q      <= c_AMMO_FULL;
      shoot_q     <= 1'b0;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ammo_q      <= ammo_d;
      shoot_q     <= shoot_d;
      fire_prev_q <= fire_req_i;
    end
  end

  // Next-state logic: a shot needs a fresh key press, READY state and ammo;
  // requests arriving while busy are dropped, not queued
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ammo_d      = ammo_q;
    shoot_d     = 1'b0;
    w_fire_edge = fire_req_i & ~fire_prev_q;
    case (state_q)
      ST_READY: begin
        if (w_fire_edge) begin
          if (ammo_q != '0) begin
            shoot_d = 1'b1;
            ammo_d  = ammo_q - 1'b1;
            state_d = ST_COOLDOWN;
            cnt_d   = c_CD_LOAD;
          end
        end else if (reload_req_i && (ammo_q < c_AMMO_FULL)) begin
          state_d = ST_RELOAD;
          cnt_d   = c_RL_LOAD;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RELOAD: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
          ammo_d  = c_AMMO_FULL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    endcase
  end

  assign shoot_o     = shoot_q;
  assign ammo_o      = ammo_q;
  assign reloading_o = (state_q == ST_RELOAD);

endmodule
`default_nettype wire

// File: rtl/tank_ctrl_p.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tank_ctrl_p
// Purpose  : Per-player tank controller, one update per video frame.
//            Keycode-driven clamped horizontal movement, saturating aim,
//            facing direction, and the weapon state machine.
// Revision : 1.0 - initial release
// ============================================================================
module tank_ctrl_p
  import tank_pkg::*;
#(
  parameter int         X_SPAWN    = 500,
  parameter int         Y_SPAWN    = 200,
  parameter int         X_MIN      = 0,
  parameter int         X_MAX      = 639,
  parameter int         SIZE       = 4,
  parameter int         STEP       = 1,
  parameter int         AIM_W      = 5,
  parameter int         AIM_MAX    = 31,
  parameter int         AMMO_MAX   = 3,
  parameter int         COOLDOWN   = 8,
  parameter int         RELOAD     = 60,
  parameter logic [7:0] KEY_LEFT   = KEYA_LEFT,
  parameter logic [7:0] KEY_RIGHT  = KEYA_RIGHT,
  parameter logic [7:0] KEY_DOWN   = KEYA_DOWN,
  parameter logic [7:0] KEY_UP     = KEYA_UP,
  parameter logic [7:0] KEY_FIRE   = KEYA_FIRE,
  parameter logic [7:0] KEY_RELOAD = KEYA_RELOAD
) (
  input  logic                              frame_clk,
  input  logic                              Reset,
  input  logic [7:0]                        keycode,
  output logic [9:0]                        TankX,
  output logic [9:0]                        TankY,
  output logic [9:0]                        TankS,
  output logic [1:0]                        Direction,
  output logic                              shoot,
  output logic [AIM_W-1:0]                  aim,
  output logic [$clog2(AMMO_MAX + 1)-1:0]   ammo,
  output logic                              reloading
);

  localparam int AMMO_W = $clog2(AMMO_MAX + 1);

  // 11-bit limits so the right-hand add can never wrap before comparing
  localparam logic [10:0]      c_STEP_W      = 11'(STEP);
  localparam logic [10:0]      c_LEFT_MOVE_W = 11'(X_MIN + SIZE + STEP);
  localparam logic [10:0]      c_RIGHT_LIM_W = 11'(X_MAX - SIZE);
  localparam logic [9:0]       c_STEP        = 10'(STEP);
  localparam logic [9:0]       c_LEFT_LIM    = 10'(X_MIN + SIZE);
  localparam logic [9:0]       c_RIGHT_LIM   = 10'(X_MAX - SIZE);
  localparam logic [9:0]       c_X_SPAWN     = 10'(X_SPAWN);
  localparam logic [AIM_W-1:0] c_AIM_MAX     = AIM_W'(AIM_MAX);

  logic [9:0]       x_q, x_d;
  logic [AIM_W-1:0] aim_q, aim_d;
  dir_t             dir_q, dir_d;
  logic [10:0]      w_x_ext;

  // Position, aim and facing registers
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      x_q   <= c_X_SPAWN;
      aim_q <= '0;
      dir_q <= DIR_RIGHT;
    end else begin
      x_q   <= x_d;
      aim_q <= aim_d;
      dir_q <= dir_d;
    end
  end

  // Key decode: compares add on the right side of the inequality so the
  // unsigned arithmetic never underflows; out-of-range moves clamp to the wall
  always_comb begin
    x_d     = x_q;
    aim_d   = aim_q;
    dir_d   = dir_q;
    w_x_ext = {1'b0, x_q};
    case (keycode)
      KEY_LEFT: begin
        dir_d = DIR_LEFT;
        if (w_x_ext >= c_LEFT_MOVE_W) x_d = x_q - c_STEP;
        else                          x_d = c_LEFT_LIM;
      end
      KEY_RIGHT: begin
        dir_d = DIR_RIGHT;
        if ((w_x_ext + c_STEP_W) <= c_RIGHT_LIM_W) x_d = x_q + c_STEP;
        else                                       x_d = c_RIGHT_LIM;
      end
      KEY_DOWN: begin
        dir_d = DIR_DOWN;
        if (aim_q != c_AIM_MAX) aim_d = aim_q + 1'b1;
      end
      KEY_UP: begin
        dir_d = DIR_UP;
        if (aim_q != '0) aim_d = aim_q - 1'b1;
      end
      default: begin
        x_d = x_q;
      end
    endcase
  end

  tank_weapon_fsm #(
    .AMMO_MAX (AMMO_MAX),
    .COOLDOWN (COOLDOWN),
    .RELOAD   (RELOAD),
    .AMMO_W   (AMMO_W)
  ) u_weapon (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .fire_req_i   (keycode == KEY_FIRE),
    .reload_req_i (keycode == KEY_RELOAD),
    .shoot_o      (shoot),
    .ammo_o       (ammo),
    .reloading_o  (reloading)
  );

  assign TankX     = x_q;
  assign TankY     = 10'(Y_SPAWN);
  assign TankS     = 10'(SIZE);
  assign Direction = dir_q;
  assign aim       = aim_q;

endmodule
`default_nettype wire

// File: doc/tank_ctrl_p.md
Name: tank_ctrl_p

Overview:
Parametrised per-player tank controller, clocked once per video frame. Decodes the keyboard keycode into clamped horizontal movement, saturating aim adjustment and facing direction. Contains a weapon state machine with a finite ammo magazine, post-shot cooldown and timed reload. Two instances, with different key maps and spawn points, drive the tank/projectile renderers and the collision logic.

Parameters:
X_SPAWN, 500, X position after reset
Y_SPAWN, 200, Y position after reset (constant; tank moves horizontally only)
X_MIN, 0, leftmost arena pixel
X_MAX, 639, rightmost arena pixel
SIZE, 4, tank half-size in pixels, drives TankS
STEP, 1, pixels moved per frame while a move key is held
AIM_W, 5, aim register width
AIM_MAX, 31, aim saturation ceiling
AMMO_MAX, 3, magazine capacity; must be at least 1
COOLDOWN, 8, frames after a shot before the next shot is allowed
RELOAD, 60, frames from reload start to full magazine
KEY_LEFT, 8'h0d / KEY_RIGHT, 8'h0f / KEY_DOWN, 8'h0e / KEY_UP, 8'h0c / KEY_FIRE, 8'h28 / KEY_RELOAD, 8'h13, key map

Ports:
frame_clk  in  1  frame-rate clock; all state updates on its rising edge
Reset  in  1  asynchronous, active-high
keycode  in  8  current USB HID keycode; 0 means no key
TankX  out  10  tank centre X
TankY  out  10  tank centre Y
TankS  out  10  half-size, constant SIZE
Direction  out  2  facing: 0 left, 1 right, 2 down, 3 up
shoot  out  1  one-frame fire pulse
aim  out  AIM_W  vertical aim component for the projectile block
ammo  out  $clog2(AMMO_MAX+1)  rounds remaining
reloading  out  1  high while in RELOAD state

Behaviour:
- Reset values: TankX=X_SPAWN, TankY=Y_SPAWN, Direction=1, shoot=0, aim=0, ammo=AMMO_MAX, state=READY, counters=0, prev_key=0.
- keycode is sampled every edge. Effects are visible on the same edge (one-frame latency); there is no separate motion register.
- KEY_LEFT: Direction<=0. If TankX >= X_MIN+SIZE+STEP then TankX-=STEP, else TankX<=X_MIN+SIZE (clamp, no bounce, no wrap).
- KEY_RIGHT: Direction<=1. If TankX+STEP <= X_MAX-SIZE then TankX+=STEP, else TankX<=X_MAX-SIZE.
- KEY_DOWN: Direction<=2; aim+=1 unless aim==AIM_MAX (saturate).
- KEY_UP: Direction<=3; aim-=1 unless aim==0 (saturate).
- All other keycodes leave position, aim and Direction unchanged.
- Unsigned 10-bit arithmetic throughout. Every compare is arranged so that no subtraction can underflow.
- Fire edge: fire_req = (keycode==KEY_FIRE) && (prev_key!=KEY_FIRE). Holding the key fires at most once.
- Weapon FSM states: READY, COOLDOWN, RELOAD.
- READY + fire_req + ammo>0: shoot=1 for exactly this frame, ammo-=1, go to COOLDOWN with cnt=COOLDOWN-1.
- READY + fire_req + ammo==0: no pulse, stay READY (dry fire).
- READY + keycode==KEY_RELOAD + ammo<AMMO_MAX: go to RELOAD with cnt=RELOAD-1.
- READY + keycode==KEY_RELOAD + ammo==AMMO_MAX: ignored.
- COOLDOWN: cnt decrements each frame; at cnt==0, go to READY. fire_req and reload requests are ignored during COOLDOWN; a held reload key is honoured after returning to READY.
- RELOAD: cnt decrements each frame; at cnt==0, ammo<=AMMO_MAX and go to READY. fire_req is ignored. Movement and aim stay active in every state.
- shoot is registered and is 0 on every frame except a granted shot.
- Reset mid-cooldown or mid-reload returns immediately to reset values; no partial ammo survives.

Decomposition:
- Package tank_pkg holds: dir_t enum (DIR_LEFT=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_UP=3), weapon_state_t enum (READY, COOLDOWN, RELOAD), and default keycode localparams for player A and player B.
- Sub-module tank_weapon_fsm holds the fire-edge detect, ammo counter, cooldown/reload counter, shoot and reloading outputs. Its inputs are frame_clk, Reset, fire_req and reload_req.
- The parent module keeps movement, aim and Direction.

Test Plan:
- Reset, then hold KEY_LEFT for 600 frames -> TankX falls 500→4 and holds at 4; Direction=0; TankY=200 throughout.
- Hold KEY_RIGHT with STEP=3, starting at X=630 -> TankX clamps at 635, never 636+ and never wraps.
- Hold KEY_DOWN for 40 frames -> aim saturates at 31. Then hold KEY_UP for 40 frames -> aim reaches 0 and stays there.
- Hold KEY_FIRE for 20 frames -> exactly one shoot pulse, ammo 3→2. Release and press again 3 frames later (inside COOLDOWN=8) -> no pulse. Press again after cooldown ends -> pulse, ammo=1.
- Fire three times, then a fourth press -> no pulse, ammo=0. Press KEY_RELOAD -> reloading=1 for 60 frames; a fire press during reload gives no pulse; then ammo=3 and reloading=0.
- Assert Reset on the 30th frame of a reload -> reloading=0, ammo=3, TankX=500, aim=0 immediately, without waiting for a clock edge.
